hermes_rx_stamp_buffer: RTL and testbench



---
 rtl/hermes_rx_stamp_buffer_pkg.sv | 9 +
 rtl/sync_fifo_ar.sv | 40 ++++
 rtl/hermes_rx_stamp_buffer.sv | 62 ++++++
 tb/tb_hermes_rx_stamp_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hermes_rx_stamp_buffer_pkg.sv
// hermes_rx_stamp_buffer_pkg: shared flit type and store-and-forward FSM states
package hermes_rx_stamp_buffer_pkg;
  localparam int HERMES_FLIT_SIZE = 32;
  typedef struct packed {
    logic                        eop;
    logic [HERMES_FLIT_SIZE-1:0] data;
  } hermes_rx_flit_t;
  typedef enum logic {RX_HOLD, RX_STREAM} rx_state_t;
endpackage

// File: rtl/sync_fifo_ar.sv
// sync_fifo_ar: first-word-fall-through FIFO with async active-high reset and occupancy count
module sync_fifo_ar #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_SIZE-1:0]         din,
  output logic [DATA_SIZE-1:0]         dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    full    = count == FULL_CNT;
    empty   = count == '0;
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr];
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/hermes_rx_stamp_buffer.sv
// hermes_rx_stamp_buffer: Hermes ingress flit buffer with per-packet EOP timestamps
module hermes_rx_stamp_buffer
  import hermes_rx_stamp_buffer_pkg::*;
#(
  parameter int FLIT_SIZE     = 32,
  parameter int BUFFER_SIZE   = 16,
  parameter int TS_DEPTH      = 4,
  parameter int TS_WIDTH      = 32,
  parameter bit STORE_FORWARD = 1'b0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [TS_WIDTH-1:0]                 tick_counter_i,
  input  logic                                rx_i,
  input  logic                                eop_i,
  input  logic [FLIT_SIZE-1:0]                data_i,
  output logic                                credit_o,
  output logic                                tx_o,
  output logic                                eop_o,
  output logic [FLIT_SIZE-1:0]                data_o,
  input  logic                                ack_i,
  output logic                                ts_valid_o,
  output logic [TS_WIDTH-1:0]                 ts_o,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]    level_o,
  output logic [$clog2(TS_DEPTH+1)-1:0]       pkt_count_o,
  output logic                                forced_o
);
  logic flit_full, flit_empty, ts_full, ts_empty, accept, pop, head_eop, escape;
  logic [FLIT_SIZE-1:0] head_data;
  logic [TS_WIDTH-1:0] ts_head;
  rx_state_t state;
  sync_fifo_ar #(.DATA_SIZE(FLIT_SIZE+1), .DEPTH(BUFFER_SIZE)) u_flit (
    .clk(clk_i), .rst(rst_i), .push(accept), .pop(pop), .din({eop_i, data_i}),
    .dout({head_eop, head_data}), .full(flit_full), .empty(flit_empty), .count(level_o)
  );
  // the stamp queue occupancy is exactly the number of complete packets held
  sync_fifo_ar #(.DATA_SIZE(TS_WIDTH), .DEPTH(TS_DEPTH)) u_ts (
    .clk(clk_i), .rst(rst_i), .push(accept && eop_i), .pop(pop && head_eop), .din(tick_counter_i),
    .dout(ts_head), .full(ts_full), .empty(ts_empty), .count(pkt_count_o)
  );
  always_comb begin
    credit_o   = !flit_full && !ts_full;
    accept     = rx_i && credit_o;
    tx_o       = (STORE_FORWARD && state == RX_HOLD) ? !ts_empty : !flit_empty;
    pop        = tx_o && ack_i;
    eop_o      = tx_o && head_eop;
    data_o     = tx_o ? head_data : '0;
    ts_valid_o = !ts_empty;
    ts_o       = ts_empty ? '0 : ts_head;
    escape     = STORE_FORWARD && state == RX_HOLD && flit_full && ts_empty;
  end
  // a packet that cannot fit is streamed through instead of deadlocking the buffer
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state    <= RX_HOLD;
      forced_o <= 1'b0;
    end else begin
      forced_o <= escape;
      state    <= state == RX_HOLD ? (escape ? RX_STREAM : RX_HOLD) : (pop && head_eop ? RX_HOLD : RX_STREAM);
    end
  stamp_present: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && head_eop && ts_empty));
endmodule

// File: tb/tb_hermes_rx_stamp_buffer.sv
// tb_hermes_rx_stamp_buffer: checks cut-through and store-and-forward instances against a queue model
module tb_hermes_rx_stamp_buffer;
  import hermes_rx_stamp_buffer_pkg::*;
  localparam int BS = 16, TD = 4;
  logic clk = 0, rst = 1, rx = 0, eop = 0, ack = 0, sf = 0;
  logic [31:0] data = 0, tick = 0;
  logic c_credit, c_tx, c_eop, c_tsv, c_forced, s_credit, s_tx, s_eop, s_tsv, s_forced;
  logic [31:0] c_data, c_ts, s_data, s_ts;
  logic [4:0] c_level, s_level;
  logic [2:0] c_pkt, s_pkt;
  wire [76:0] c_all = {c_credit, c_tx, c_eop, c_data, c_tsv, c_ts, c_level, c_pkt, c_forced};
  wire [76:0] s_all = {s_credit, s_tx, s_eop, s_data, s_tsv, s_ts, s_level, s_pkt, s_forced};
  wire [76:0] o_all = sf ? s_all : c_all;
  hermes_rx_flit_t fq[$];
  logic [31:0] tq[$];
  bit m_stream, m_forced, m_acc;
  int n_checks = 0, n_fail = 0;

  hermes_rx_stamp_buffer #(.STORE_FORWARD(1'b0)) dut_ct (
    .clk_i(clk), .rst_i(rst), .tick_counter_i(tick), .rx_i(rx), .eop_i(eop), .data_i(data),
    .credit_o(c_credit), .tx_o(c_tx), .eop_o(c_eop), .data_o(c_data), .ack_i(ack),
    .ts_valid_o(c_tsv), .ts_o(c_ts), .level_o(c_level), .pkt_count_o(c_pkt), .forced_o(c_forced));
  hermes_rx_stamp_buffer #(.STORE_FORWARD(1'b1)) dut_sf (
    .clk_i(clk), .rst_i(rst), .tick_counter_i(tick), .rx_i(rx), .eop_i(eop), .data_i(data),
    .credit_o(s_credit), .tx_o(s_tx), .eop_o(s_eop), .data_o(s_data), .ack_i(ack),
    .ts_valid_o(s_tsv), .ts_o(s_ts), .level_o(s_level), .pkt_count_o(s_pkt), .forced_o(s_forced));

  always #5 clk = ~clk;

  function automatic bit m_credit();
    return fq.size() < BS && tq.size() < TD;
  endfunction
  function automatic bit m_tx();
    return (sf && !m_stream) ? tq.size() > 0 : fq.size() > 0;
  endfunction
  function automatic logic [76:0] exp_all();
    hermes_rx_flit_t h;
    logic [31:0] ts;
    logic t;
    h = '0;
    ts = '0;
    t = m_tx();
    if (fq.size() > 0) h = fq[0];
    if (tq.size() > 0) ts = tq[0];
    return {m_credit(), t, t & h.eop, t ? h.data : 32'h0, tq.size() > 0, ts, 5'(fq.size()), 3'(tq.size()), m_forced};
  endfunction

  task automatic do_reset();
    rx = 0; eop = 0; data = 0; ack = 0; tick = 0;
    rst = 1;
    #3;
    fq.delete(); tq.delete(); m_stream = 0; m_forced = 0; m_acc = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // one clock of stimulus; the model advances with the same accept/pop rules as the buffer contract
  task automatic drive(input logic r, input logic e, input logic [31:0] d, input logic a, input logic [31:0] t);
    hermes_rx_flit_t h, nf;
    bit popd, esc;
    rx = r; eop = e; data = d; ack = a; tick = t;
    m_acc = r && m_credit();
    popd = a && m_tx();
    esc = sf && !m_stream && fq.size() == BS && tq.size() == 0;
    @(posedge clk);
    h = '0;
    if (popd) begin
      h = fq.pop_front();
      if (h.eop) void'(tq.pop_front());
    end
    if (m_acc) begin
      nf.eop = e; nf.data = d;
      fq.push_back(nf);
      if (e) tq.push_back(t);
    end
    m_stream = m_stream ? !(popd && h.eop) : esc;
    m_forced = esc;
    #1;
  endtask

  task automatic test_reset();
    sf = 0;
    do_reset();
    n_checks++; if (c_all !== {1'b1, 76'b0}) begin n_fail++; $display("FAIL reset_ct: got %h exp %h", c_all, {1'b1, 76'b0}); end
    n_checks++; if (s_all !== {1'b1, 76'b0}) begin n_fail++; $display("FAIL reset_sf: got %h exp %h", s_all, {1'b1, 76'b0}); end
  endtask

  task automatic test_cut_through();
    logic [31:0] fl [3] = '{32'hA1, 32'hA2, 32'hA3};
    sf = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 2, fl[i], 0, 98 + i);
      n_checks++; if (o_all !== exp_all()) begin n_fail++; $display("FAIL ct_accept%0d: got %h exp %h", i, o_all, exp_all()); end
    end
    n_checks++; if ({c_tx, c_data, c_tsv, c_ts, c_pkt} !== {1'b1, 32'hA1, 1'b1, 32'd100, 3'd1}) begin
      n_fail++; $display("FAIL ct_stamp: got tx=%b data=%h tsv=%b ts=%0d pkt=%0d exp 1 a1 1 100 1", c_tx, c_data, c_tsv, c_ts, c_pkt);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({c_tx, c_eop, c_data} !== {1'b1, i == 2, fl[i]}) begin n_fail++; $display("FAIL ct_head%0d: got %b %b %h exp 1 %b %h", i, c_tx, c_eop, c_data, i == 2, fl[i]); end
      drive(0, 0, 0, 1, 0);
      n_checks++; if (o_all !== exp_all()) begin n_fail++; $display("FAIL ct_pop%0d: got %h exp %h", i, o_all, exp_all()); end
    end
    n_checks++; if ({c_tsv, c_ts, c_tx} !== 34'b0) begin n_fail++; $display("FAIL ct_release: got tsv=%b ts=%0d tx=%b exp 0 0 0", c_tsv, c_ts, c_tx); end
  endtask

  task automatic test_back_to_back();
    sf = 0;
    do_reset();
    drive(1, 1, 32'hB1, 0, 200);
    drive(1, 1, 32'hB2, 0, 201);
    n_checks++; if ({c_pkt, c_ts} !== {3'd2, 32'd200}) begin n_fail++; $display("FAIL b2b_two: got pkt=%0d ts=%0d exp 2 200", c_pkt, c_ts); end
    drive(0, 0, 0, 1, 0);
    n_checks++; if ({c_tsv, c_ts, c_pkt} !== {1'b1, 32'd201, 3'd1}) begin n_fail++; $display("FAIL b2b_first_pop: got tsv=%b ts=%0d pkt=%0d exp 1 201 1", c_tsv, c_ts, c_pkt); end
    drive(0, 0, 0, 1, 0);
    n_checks++; if ({c_tsv, c_pkt} !== 4'b0) begin n_fail++; $display("FAIL b2b_second_pop: got tsv=%b pkt=%0d exp 0 0", c_tsv, c_pkt); end
  endtask

  task automatic test_full();
    sf = 0;
    do_reset();
    for (int i = 0; i < BS; i++) drive(1, 0, $urandom, 0, 0);
    n_checks++; if ({c_credit, c_level} !== {1'b0, 5'd16}) begin n_fail++; $display("FAIL full: got credit=%b level=%0d exp 0 16", c_credit, c_level); end
    drive(0, 0, 0, 1, 0);
    n_checks++; if ({c_credit, c_level} !== {1'b1, 5'd15}) begin n_fail++; $display("FAIL full_pop: got credit=%b level=%0d exp 1 15", c_credit, c_level); end
    drive(1, 0, $urandom, 1, 0);
    n_checks++; if (c_level !== 5'd15 || o_all !== exp_all()) begin n_fail++; $display("FAIL full_simul: got %h exp %h", o_all, exp_all()); end
  endtask

  task automatic test_wrap();
    int sent = 0, cyc = 0;
    sf = 0;
    do_reset();
    for (cyc = 0; cyc < 1000 && (sent < 40 || fq.size() > 0); cyc++) begin
      drive(sent < 40 && $urandom_range(3) != 0, $urandom_range(7) == 0, $urandom, sent >= 40 || $urandom_range(1) == 1, $urandom);
      if (m_acc) sent++;
      n_checks++; if (o_all !== exp_all()) begin n_fail++; $display("FAIL wrap_cyc%0d: got %h exp %h", cyc, o_all, exp_all()); end
    end
    n_checks++; if (cyc >= 1000 || c_level !== 5'd0) begin n_fail++; $display("FAIL wrap_done: got level=%0d cycles=%0d exp level 0 within 1000", c_level, cyc); end
  endtask

  task automatic test_ts_limit();
    sf = 0;
    do_reset();
    for (int i = 0; i < TD; i++) drive(1, 1, 32'hD0 + i, 0, 300 + i);
    n_checks++; if ({c_credit, c_level, c_pkt} !== {1'b0, 5'd4, 3'd4}) begin n_fail++; $display("FAIL ts_limit: got credit=%b level=%0d pkt=%0d exp 0 4 4", c_credit, c_level, c_pkt); end
    drive(1, 1, 32'hDD, 0, 400);
    n_checks++; if (o_all !== exp_all() || c_level !== 5'd4) begin n_fail++; $display("FAIL ts_limit_hold: got %h exp %h", o_all, exp_all()); end
  endtask

  task automatic test_sf_basic();
    sf = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 2, 32'hE1 + i, 1, 600);
      n_checks++; if (s_tx !== (i == 2) || o_all !== exp_all()) begin n_fail++; $display("FAIL sf_hold%0d: got %h exp %h", i, o_all, exp_all()); end
    end
    n_checks++; if ({s_tx, s_data, s_ts} !== {1'b1, 32'hE1, 32'd600}) begin n_fail++; $display("FAIL sf_release: got tx=%b data=%h ts=%0d exp 1 e1 600", s_tx, s_data, s_ts); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      n_checks++; if (o_all !== exp_all()) begin n_fail++; $display("FAIL sf_drain%0d: got %h exp %h", i, o_all, exp_all()); end
    end
  endtask

  task automatic test_sf_forced();
    int sent = 0, cyc = 0, pulses = 0;
    sf = 1;
    do_reset();
    for (cyc = 0; cyc < 200 && !(sent == 20 && fq.size() == 0); cyc++) begin
      drive(sent < 20, sent == 19, 32'hF000 + sent, 1, 700 + cyc);
      if (m_acc) sent++;
      pulses += int'(s_forced);
      n_checks++; if (o_all !== exp_all()) begin n_fail++; $display("FAIL sf_forced_cyc%0d: got %h exp %h", cyc, o_all, exp_all()); end
    end
    n_checks++; if (pulses != 1 || cyc >= 200 || s_level !== 5'd0) begin n_fail++; $display("FAIL sf_forced_pulse: got pulses=%0d level=%0d cycles=%0d exp 1 0 <200", pulses, s_level, cyc); end
    drive(1, 0, 32'h55, 1, 0);
    n_checks++; if ({s_tx, s_level} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL sf_back_to_hold: got tx=%b level=%0d exp 0 1", s_tx, s_level); end
  endtask

  task automatic test_sf_reset_mid();
    sf = 1;
    do_reset();
    drive(1, 0, 32'hC0, 0, 0);
    drive(1, 0, 32'hC9, 0, 0);
    #2 rst = 1;
    #1;
    n_checks++; if ({s_level, s_tx, s_credit} !== {5'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL sf_rst_mid: got level=%0d tx=%b credit=%b exp 0 0 1", s_level, s_tx, s_credit); end
    do_reset();
    drive(1, 0, 32'hC1, 0, 499);
    drive(1, 1, 32'hC2, 0, 500);
    n_checks++; if ({s_tx, s_data, s_ts, s_level} !== {1'b1, 32'hC1, 32'd500, 5'd2}) begin n_fail++; $display("FAIL sf_after_rst: got tx=%b data=%h ts=%0d level=%0d exp 1 c1 500 2", s_tx, s_data, s_ts, s_level); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0);
      n_checks++; if (o_all !== exp_all()) begin n_fail++; $display("FAIL sf_after_rst_drain%0d: got %h exp %h", i, o_all, exp_all()); end
    end
  endtask

  initial begin
    test_reset();
    test_cut_through();
    test_back_to_back();
    test_full();
    test_wrap();
    test_ts_limit();
    test_sf_basic();
    test_sf_forced();
    test_sf_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
